// File: rtl/stopwatch_seq.sv
// Stopwatch sequencer: direction/digit-set FSM, 0.1 s prescaler and goal register driving an external BCD counter.
// Button pulses land one cycle later; load/step are one-cycle registered commands, no backpressure from the counter.
module stopwatch_seq #(
    parameter int TICK_DIV = 10_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        enter_p,
    input  logic        inc_p,
    input  logic        dir_p,
    input  logic        at_goal,
    output logic [2:0]  state,
    output logic [15:0] set_time,
    output logic        load,
    output logic [15:0] load_value,
    output logic [15:0] goal,
    output logic        step,
    output logic        dir_down,
    output logic        blank,
    output logic        done
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] P_PRE  = PW'(TICK_DIV - 2);

    typedef enum logic [2:0] {
        S_DIR       = 3'd0,
        S_SET_MIN   = 3'd1,
        S_SET_TEN   = 3'd2,
        S_SET_SEC   = 3'd3,
        S_SET_TENTH = 3'd4,
        S_RUN       = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    state_t          r_state,      w_state_nxt;
    logic [15:0]     r_set_time,   w_set_nxt;
    logic [15:0]     r_goal,       w_goal_nxt;
    logic [15:0]     r_load_value, w_lv_nxt;
    logic            r_dir_down,   w_dir_nxt;
    logic            r_load,       w_load_nxt;
    logic            r_step,       w_step_nxt;
    logic [PW-1:0]   r_presc,      w_presc_nxt;
    logic            w_count;

    function automatic logic [3:0] wrap_inc(input logic [3:0] v, input logic [3:0] lim);
        return (v >= lim) ? 4'd0 : v + 4'd1;
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_set_nxt   = r_set_time;
        w_goal_nxt  = r_goal;
        w_lv_nxt    = r_load_value;
        w_dir_nxt   = r_dir_down;
        w_load_nxt  = 1'b0;
        w_step_nxt  = 1'b0;
        w_presc_nxt = r_presc;
        w_count     = 1'b0;
        case (r_state)
            S_DIR: begin
                if (dir_p)   w_dir_nxt   = ~r_dir_down;
                if (enter_p) w_state_nxt = S_SET_MIN;
            end
            S_SET_MIN: begin
                if (inc_p)   w_set_nxt[15:12] = wrap_inc(r_set_time[15:12], 4'd1);
                if (enter_p) w_state_nxt      = S_SET_TEN;
            end
            S_SET_TEN: begin
                if (inc_p)   w_set_nxt[11:8] = wrap_inc(r_set_time[11:8], 4'd5);
                if (enter_p) w_state_nxt     = S_SET_SEC;
            end
            S_SET_SEC: begin
                if (inc_p)   w_set_nxt[7:4] = wrap_inc(r_set_time[7:4], 4'd9);
                if (enter_p) w_state_nxt    = S_SET_TENTH;
            end
            S_SET_TENTH: begin
                if (inc_p) w_set_nxt[3:0] = wrap_inc(r_set_time[3:0], 4'd9);
                if (enter_p) begin
                    w_state_nxt = S_RUN;
                    w_load_nxt  = 1'b1;
                    w_goal_nxt  = r_dir_down ? 16'h0000 : w_set_nxt;
                    w_lv_nxt    = r_dir_down ? w_set_nxt : 16'h0000;
                end
            end
            S_RUN: begin
                w_count = en && !r_load;
                if (w_count)
                    w_presc_nxt = (r_presc == P_LAST) ? '0 : r_presc + PW'(1);
                // step is issued one cycle ahead so it is visible while the prescaler sits at its last count
                if (!r_load && at_goal)
                    w_state_nxt = S_DONE;
                else if (w_count && r_presc == P_PRE)
                    w_step_nxt = 1'b1;
            end
            S_DONE: begin
                if (enter_p) begin
                    w_state_nxt = S_DIR;
                    w_set_nxt   = 16'h0000;
                    w_goal_nxt  = 16'h0000;
                    w_lv_nxt    = 16'h0000;
                    w_presc_nxt = '0;
                end
            end
            default: w_state_nxt = S_DIR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_DIR;
            r_set_time   <= 16'h0000;
            r_goal       <= 16'h0000;
            r_load_value <= 16'h0000;
            r_dir_down   <= 1'b0;
            r_load       <= 1'b0;
            r_step       <= 1'b0;
            r_presc      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_set_time   <= w_set_nxt;
            r_goal       <= w_goal_nxt;
            r_load_value <= w_lv_nxt;
            r_dir_down   <= w_dir_nxt;
            r_load       <= w_load_nxt;
            r_step       <= w_step_nxt;
            r_presc      <= w_presc_nxt;
        end
    end

    assign state      = r_state;
    assign set_time   = r_set_time;
    assign load       = r_load;
    assign load_value = r_load_value;
    assign goal       = r_goal;
    assign step       = r_step;
    assign dir_down   = r_dir_down;
    assign blank      = (r_state == S_DIR);
    assign done       = (r_state == S_DONE);
endmodule

// File: tb/tb_stopwatch_seq.sv
// Bench for stopwatch_seq with a behavioural BCD counter closing the at_goal loop.
module tb_stopwatch_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b1;
    logic        enter_p = 1'b0;
    logic        inc_p = 1'b0;
    logic        dir_p = 1'b0;
    logic        at_goal;
    logic [2:0]  state;
    logic [15:0] set_time, load_value, goal;
    logic        load, step, dir_down, blank, done;
    logic [15:0] cnt = 16'h0000;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          exp_q[$];

    stopwatch_seq #(.TICK_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .enter_p(enter_p), .inc_p(inc_p),
        .dir_p(dir_p), .at_goal(at_goal), .state(state), .set_time(set_time),
        .load(load), .load_value(load_value), .goal(goal), .step(step),
        .dir_down(dir_down), .blank(blank), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (r[3:0] != 4'd9) r[3:0] = r[3:0] + 4'd1;
        else begin
            r[3:0] = 4'd0;
            if (r[7:4] != 4'd9) r[7:4] = r[7:4] + 4'd1;
            else begin
                r[7:4] = 4'd0;
                if (r[11:8] != 4'd5) r[11:8] = r[11:8] + 4'd1;
                else begin
                    r[11:8]  = 4'd0;
                    r[15:12] = r[15:12] + 4'd1;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (r[3:0] != 4'd0) r[3:0] = r[3:0] - 4'd1;
        else begin
            r[3:0] = 4'd9;
            if (r[7:4] != 4'd0) r[7:4] = r[7:4] - 4'd1;
            else begin
                r[7:4] = 4'd9;
                if (r[11:8] != 4'd0) r[11:8] = r[11:8] - 4'd1;
                else begin
                    r[11:8]  = 4'd5;
                    r[15:12] = r[15:12] - 4'd1;
                end
            end
        end
        return r;
    endfunction

    // counter datapath model: takes load_value / steps on the edge ending the command cycle
    always @(posedge clk) begin
        if (load) cnt <= load_value;
        else if (step) cnt <= dir_down ? bcd_dec(cnt) : bcd_inc(cnt);
    end
    assign at_goal = (cnt == goal);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic press_enter;
        enter_p = 1'b1; tick(); enter_p = 1'b0;
    endtask

    task automatic press_inc;
        inc_p = 1'b1; tick(); inc_p = 1'b0;
    endtask

    task automatic press_dir;
        dir_p = 1'b1; tick(); dir_p = 1'b0;
    endtask

    task automatic do_reset;
        en = 1'b1;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic set_and_run(input logic down, input int m, input int t, input int s, input int d);
        do_reset();
        if (down) press_dir();
        press_enter();
        repeat (m) press_inc();
        press_enter();
        repeat (t) press_inc();
        press_enter();
        repeat (s) press_inc();
        press_enter();
        repeat (d) press_inc();
        press_enter();
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        #1;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (set_time !== 16'h0) begin errors++; $display("FAIL reset_set_time got=%h exp=0000", set_time); end
        checks++; if (goal !== 16'h0 || load_value !== 16'h0) begin errors++; $display("FAIL reset_goal_lv got=%h/%h exp=0000/0000", goal, load_value); end
        checks++; if ({dir_down, load, step, done, blank} !== 5'b00001) begin errors++; $display("FAIL reset_flags got=%b exp=00001", {dir_down, load, step, done, blank}); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_dir;
        repeat (3) press_dir();
        checks++; if (dir_down !== 1'b1) begin errors++; $display("FAIL dir_toggle got=%b exp=1", dir_down); end
        press_enter();
        checks++; if (state !== 3'd1 || blank !== 1'b0) begin errors++; $display("FAIL dir_enter state=%0d blank=%b exp=1/0", state, blank); end
        press_dir();
        checks++; if (dir_down !== 1'b1) begin errors++; $display("FAIL dir_ignored got=%b exp=1", dir_down); end
    endtask

    task automatic test_set_fields;
        repeat (3) press_inc();
        checks++; if (set_time[15:12] !== 4'd1) begin errors++; $display("FAIL min_wrap got=%0d exp=1", set_time[15:12]); end
        press_enter();
        repeat (7) press_inc();
        checks++; if (set_time !== 16'h1100) begin errors++; $display("FAIL ten_wrap got=%h exp=1100", set_time); end
        inc_p = 1'b1; enter_p = 1'b1; tick(); inc_p = 1'b0; enter_p = 1'b0;
        checks++; if (state !== 3'd3 || set_time !== 16'h1200) begin errors++; $display("FAIL inc_enter state=%0d set=%h exp=3/1200", state, set_time); end
        repeat (11) press_inc();
        checks++; if (set_time !== 16'h1210) begin errors++; $display("FAIL sec_wrap got=%h exp=1210", set_time); end
    endtask

    task automatic test_count_up;
        int L, done_cyc, extra_loads;
        set_and_run(1'b0, 0, 0, 1, 2);
        L = cyc; done_cyc = -1; extra_loads = 0;
        checks++; if (state !== 3'd5 || load !== 1'b1) begin errors++; $display("FAIL up_load state=%0d load=%b exp=5/1", state, load); end
        checks++; if (load_value !== 16'h0000 || goal !== 16'h0012) begin errors++; $display("FAIL up_regs lv=%h goal=%h exp=0000/0012", load_value, goal); end
        exp_q.delete();
        for (int k = 1; k <= 12; k++) exp_q.push_back(L + 4 * k);
        for (int i = 0; i < 200 && done_cyc < 0; i++) begin
            tick();
            if (load) extra_loads++;
            if (step) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL up_step unexpected at cycle %0d", cyc - L); end
                else begin
                    int e;
                    e = exp_q.pop_front();
                    if (cyc !== e) begin errors++; $display("FAIL up_step got=%0d exp=%0d", cyc - L, e - L); end
                end
            end
            if (done) done_cyc = cyc;
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL up_steps_missing got=%0d exp=0", exp_q.size()); end
        checks++; if (done_cyc !== L + 50) begin errors++; $display("FAIL up_done_cycle got=%0d exp=50", done_cyc - L); end
        checks++; if (cnt !== 16'h0012 || extra_loads != 0) begin errors++; $display("FAIL up_final cnt=%h loads=%0d exp=0012/0", cnt, extra_loads); end
    endtask

    task automatic test_pause;
        int L, done_cyc, paused, nsteps;
        set_and_run(1'b1, 0, 0, 0, 3);
        L = cyc; done_cyc = -1; paused = 0; nsteps = 0;
        checks++; if (load_value !== 16'h0003 || goal !== 16'h0000) begin errors++; $display("FAIL dn_regs lv=%h goal=%h exp=0003/0000", load_value, goal); end
        exp_q.delete();
        exp_q.push_back(L + 4);
        exp_q.push_back(L + 18);
        exp_q.push_back(L + 22);
        for (int i = 0; i < 200 && done_cyc < 0; i++) begin
            tick();
            if (paused > 0) begin
                paused--;
                if (paused == 0) en = 1'b1;
            end
            if (step) begin
                nsteps++;
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL dn_step unexpected at cycle %0d", cyc - L); end
                else begin
                    int e;
                    e = exp_q.pop_front();
                    if (cyc !== e) begin errors++; $display("FAIL dn_step got=%0d exp=%0d", cyc - L, e - L); end
                end
                if (nsteps == 1) begin en = 1'b0; paused = 10; end
            end
            if (done) done_cyc = cyc;
        end
        en = 1'b1;
        checks++; if (nsteps != 3 || cnt !== 16'h0000) begin errors++; $display("FAIL dn_final steps=%0d cnt=%h exp=3/0000", nsteps, cnt); end
        checks++; if (done_cyc !== L + 24) begin errors++; $display("FAIL dn_done_cycle got=%0d exp=24", done_cyc - L); end
        press_enter();
        checks++; if (state !== 3'd0 || dir_down !== 1'b1) begin errors++; $display("FAIL dn_exit state=%0d dir=%b exp=0/1", state, dir_down); end
    endtask

    task automatic test_zero;
        int L, done_cyc, nsteps;
        set_and_run(1'b0, 0, 0, 0, 0);
        L = cyc; done_cyc = -1; nsteps = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (step) nsteps++;
            if (done && done_cyc < 0) done_cyc = cyc;
        end
        checks++; if (nsteps != 0) begin errors++; $display("FAIL zero_steps got=%0d exp=0", nsteps); end
        checks++; if (done_cyc !== L + 2) begin errors++; $display("FAIL zero_done_cycle got=%0d exp=2", done_cyc - L); end
        press_enter();
        checks++; if (state !== 3'd0 || set_time !== 16'h0 || goal !== 16'h0 || dir_down !== 1'b0) begin
            errors++; $display("FAIL zero_exit state=%0d set=%h goal=%h dir=%b exp=0/0000/0000/0", state, set_time, goal, dir_down);
        end
    endtask

    task automatic test_reset_mid_run;
        int nsteps;
        nsteps = 0;
        set_and_run(1'b1, 0, 0, 1, 0);
        repeat (6) tick();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (state !== 3'd0 || set_time !== 16'h0 || goal !== 16'h0 || load_value !== 16'h0) begin
            errors++; $display("FAIL mid_reset_regs state=%0d set=%h goal=%h lv=%h exp=0/0000/0000/0000", state, set_time, goal, load_value);
        end
        checks++; if ({dir_down, load, step, done, blank} !== 5'b00001) begin errors++; $display("FAIL mid_reset_flags got=%b exp=00001", {dir_down, load, step, done, blank}); end
        #9 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (step) nsteps++;
        end
        checks++; if (nsteps != 0 || state !== 3'd0) begin errors++; $display("FAIL mid_reset_after steps=%0d state=%0d exp=0/0", nsteps, state); end
    endtask

    initial begin
        test_reset();
        test_dir();
        test_set_fields();
        test_count_up();
        test_pause();
        test_zero();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
